// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device using the host request-to-send
// sequence, then checks the device acknowledge. The PS2_CLK/PS2_DAT lines
// are open-drain. This block only produces active-high pull-low enables,
// and the top level turns them into the tri-state pin drivers.
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] command,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q,   state_d;
  logic [8:0]       shift_q,   shift_d;    // {parity, data[7:0]}, LSB goes out first
  logic [3:0]       bit_cnt_q, bit_cnt_d;  // device clock edges consumed so far
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
  logic             clk_drv_q, clk_drv_d;
  logic             dat_drv_q, dat_drv_d;
  logic             done_q,    done_d;
  logic             error_q,   error_d;

  // Synchronizer chains. The clock chain has a third stage for edge detection.
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_s;
  logic       dat_s;
  logic       fall;
  logic       timed_state;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_sync_q[2] & ~clk_sync_q[1];

  // Timeout supervision only while waiting on the device.
  assign timed_state = (state_q == S_REQUEST) || (state_q == S_SEND) ||
                       (state_q == S_ACK)     || (state_q == S_WAIT_IDLE);

  // Two-flop synchronizers. They reset to the idle (released) line level so
  // that leaving reset never looks like a falling clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_data_in};
    end
  end

  // Next-state, counters and registered line-drive decisions.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_drv_d = clk_drv_q;
    dat_drv_d = dat_drv_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (start) begin
          shift_d   = {~^command, command};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          clk_drv_d = 1'b1;
          // A one-cycle inhibit puts the start bit on in its only cycle.
          dat_drv_d = (INH_LAST == '0);
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          // Release the clock and keep the start bit on the data line.
          clk_drv_d = 1'b0;
          dat_drv_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = S_REQUEST;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          // Start bit overlaps the final clock-low cycle by one cycle.
          if (inh_cnt_d == INH_LAST) begin
            dat_drv_d = 1'b1;
          end
        end
      end

      // The clock fall caused by our own inhibit is synchronized and gone
      // long before the inhibit ends, so any fall seen here is the device's.
      S_REQUEST: begin
        if (fall) begin
          dat_drv_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_cnt_d = 4'd1;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (fall) begin
          if (bit_cnt_q == 4'd9) begin
            // Tenth edge: release data for the stop bit, then expect ACK.
            dat_drv_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            dat_drv_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      S_ACK: begin
        if (fall) begin
          if (!dat_s) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timeout restarts on every state change and on every device clock fall.
    // A normal state change wins over an expiry in the same cycle, which
    // keeps done and error mutually exclusive.
    if (timed_state) begin
      if ((state_d != state_q) || fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        error_d  = 1'b1;
        done_d   = 1'b0;
        state_d  = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    // Whatever path leads back to IDLE, both lines are released.
    if (state_d == S_IDLE) begin
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
    end
  end

  // State, datapath and output registers. Reset releases the lines at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_drv_q <= 1'b0;
      dat_drv_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_drv_q <= clk_drv_d;
      dat_drv_q <= dat_drv_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ready              = (state_q == S_IDLE);
  assign busy               = ~ready;
  assign done               = done_q;
  assign error              = error_q;
  assign ps2_clk_drive_low  = clk_drv_q;
  assign ps2_data_drive_low = dat_drv_q;

endmodule
